// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_pkg
// Description : Shared helpers for the buffered packet stream stage.
//               Width helpers derive pointer/count widths from the depth, and
//               the mode constants name the two egress policies.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_pkg;

  // Egress policies selected by PACKET_MODE
  localparam int PKT_MODE_CUT_THROUGH = 0;
  localparam int PKT_MODE_STORE_FWD   = 1;

  // Address bits needed to index DEPTH entries (DEPTH is a power of 2, >= 2)
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Pointer/count width: one extra bit separates full from empty and lets
  // counts reach DEPTH itself
  function automatic int cnt_w(input int depth);
    return addr_w(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : stream_fifo_ram
// Description : DEPTH x (DATA_WIDTH+1) storage for the packet FIFO.
//               Synchronous write, asynchronous read, no reset on the array.
// Ports       : clk        - clock, write on rising edge
//               i_wr_en    - write strobe
//               i_wr_addr  - write address
//               i_wr_data  - {last, data} word to store
//               i_rd_addr  - read address
//               o_rd_data  - {last, data} word at i_rd_addr (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module stream_fifo_ram
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                      clk,
  input  logic                      i_wr_en,
  input  logic [addr_w(DEPTH)-1:0]  i_wr_addr,
  input  logic [DATA_WIDTH:0]       i_wr_data,
  input  logic [addr_w(DEPTH)-1:0]  i_rd_addr,
  output logic [DATA_WIDTH:0]       o_rd_data
);

  logic [DATA_WIDTH:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/stream_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : stream_pkt_fifo
// Description : Buffered stream stage carrying data/last/valid/ready.
//               PACKET_MODE 0: cut-through FIFO.
//               PACKET_MODE 1: store-and-forward; a packet is offered
//               downstream only once its last beat is stored, with a
//               full-storage escape so packets longer than DEPTH still drain.
// Ports       : clk      - clock, rising edge
//               rst      - asynchronous active-low reset
//               s_data   - upstream beat data
//               s_valid  - upstream beat valid
//               s_last   - upstream end of packet
//               s_ready  - beat can be accepted (not full)
//               m_data   - downstream beat data
//               m_valid  - downstream beat valid
//               m_last   - downstream end of packet
//               m_ready  - downstream accepts the beat
//               fill     - stored beat count, 0..DEPTH
//               pkt_cnt  - complete packets stored (last beats held)
// Revision    : 1.0 - initial release
// ============================================================================
module stream_pkt_fifo
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic                    m_valid,
  output logic                    m_last,
  input  logic                    m_ready,
  output logic [$clog2(DEPTH):0]  fill,
  output logic [$clog2(DEPTH):0]  pkt_cnt
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CNT_W  = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } stream_beat_t;

  logic [CNT_W-1:0]    r_wr_ptr;
  logic [CNT_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_fill;
  logic [CNT_W-1:0]    r_pkt_cnt;

  stream_beat_t        w_wr_beat;
  stream_beat_t        w_rd_beat;
  logic [DATA_WIDTH:0] w_rd_word;
  logic                w_empty;
  logic                w_full;
  logic                w_wr;
  logic                w_rd;
  logic                w_m_valid;
  logic                w_pkt_in;
  logic                w_pkt_out;

  // --------------------------------------------------------------------------
  // Status from registered pointers only; nothing passes straight through
  // --------------------------------------------------------------------------
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                   (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);

  generate
    if (PACKET_MODE == PKT_MODE_STORE_FWD) begin : g_store_fwd
      // Hold back until a whole packet is stored. The full term releases an
      // oversize packet that could otherwise never complete.
      assign w_m_valid = !w_empty && ((r_pkt_cnt != '0) || w_full);
    end else begin : g_cut_through
      assign w_m_valid = !w_empty;
    end
  endgenerate

  assign s_ready = !w_full;
  assign m_valid = w_m_valid;

  assign w_wr      = s_valid && !w_full;
  assign w_rd      = w_m_valid && m_ready;
  assign w_pkt_in  = w_wr && s_last;
  assign w_pkt_out = w_rd && w_rd_beat.last;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  assign w_wr_beat.last = s_last;
  assign w_wr_beat.data = s_data;

  stream_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr),
    .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
    .i_wr_data (w_wr_beat),
    .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
    .o_rd_data (w_rd_word)
  );

  assign w_rd_beat = w_rd_word;
  assign m_data    = w_rd_beat.data;
  assign m_last    = w_rd_beat.last;

  // --------------------------------------------------------------------------
  // Pointers and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + c_cnt_one;
      if (w_rd) r_rd_ptr <= r_rd_ptr + c_cnt_one;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fill <= '0;
    end else begin
      case ({w_wr, w_rd})
        2'b10:   r_fill <= r_fill + c_cnt_one;
        2'b01:   r_fill <= r_fill - c_cnt_one;
        default: r_fill <= r_fill;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pkt_cnt <= '0;
    end else begin
      case ({w_pkt_in, w_pkt_out})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + c_cnt_one;
        2'b01:   r_pkt_cnt <= r_pkt_cnt - c_cnt_one;
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
    end
  end

  assign fill    = r_fill;
  assign pkt_cnt = r_pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_stream_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_pkt_fifo
// Description : Self-checking bench for stream_pkt_fifo. Two DEPTH=4 copies
//               (cut-through and store-and-forward) share the stimulus; the
//               selected copy's outputs are checked against hand-computed
//               values and, in the random phase, a queue scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_pkt_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int NBEAT = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_last;
  logic          m_ready;
  logic          sel;

  logic          s_ready0, m_valid0, m_last0;
  logic [DW-1:0] m_data0;
  logic [2:0]    fill0, pkt0;
  logic          s_ready1, m_valid1, m_last1;
  logic [DW-1:0] m_data1;
  logic [2:0]    fill1, pkt1;

  logic          s_ready, m_valid, m_last;
  logic [DW-1:0] m_data;
  logic [2:0]    fill, pkt_cnt;

  int n_cmp = 0;
  int n_err = 0;

  stream_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PACKET_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready0),
    .m_data(m_data0), .m_valid(m_valid0), .m_last(m_last0), .m_ready(m_ready),
    .fill(fill0), .pkt_cnt(pkt0)
  );

  stream_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PACKET_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready1),
    .m_data(m_data1), .m_valid(m_valid1), .m_last(m_last1), .m_ready(m_ready),
    .fill(fill1), .pkt_cnt(pkt1)
  );

  assign s_ready = sel ? s_ready1 : s_ready0;
  assign m_valid = sel ? m_valid1 : m_valid0;
  assign m_last  = sel ? m_last1  : m_last0;
  assign m_data  = sel ? m_data1  : m_data0;
  assign fill    = sel ? fill1    : fill0;
  assign pkt_cnt = sel ? pkt1     : pkt0;

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic which);
    sel     = which;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    rst     = 1'b0;
    #3;
    rst     = 1'b1;
    tick();
  endtask

  function automatic int count_last(input logic [DW:0] q[$]);
    int n = 0;
    foreach (q[i]) if (q[i][DW]) n++;
    return n;
  endfunction

  task automatic run_random(input logic which, input string tag);
    logic [DW:0] q[$];
    logic [DW:0] exp_beat;
    logic [DW:0] prev_beat = '0;
    logic        prev_mv = 1'b0;
    logic        prev_rd = 1'b0;
    logic        pend = 1'b0;
    logic        wr, rd;
    int          sent = 0;
    int          recv = 0;
    int          pkt_left = 0;
    do_reset(which);
    for (int cyc = 0; cyc < 20000 && recv < NBEAT; cyc++) begin
      if (!pend) begin
        if (sent < NBEAT && $urandom_range(0, 3) != 0) begin
          if (pkt_left == 0) pkt_left = $urandom_range(1, 8);
          s_valid = 1'b1;
          s_data  = DW'($urandom);
          s_last  = (pkt_left == 1) || (sent == NBEAT - 1);
        end else begin
          s_valid = 1'b0;
        end
      end
      m_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk({tag, "_fill"}, 32'(fill), 32'(q.size()));
      chk({tag, "_pkt"}, 32'(pkt_cnt), 32'(count_last(q)));
      chk({tag, "_fill_max"}, 32'(fill <= 3'(DEPTH)), 32'd1);
      if (prev_mv && !prev_rd) begin
        chk({tag, "_hold_valid"}, 32'(m_valid), 32'd1);
        chk({tag, "_hold_beat"}, 32'({m_last, m_data}), 32'(prev_beat));
      end
      wr = s_valid && s_ready;
      rd = m_valid && m_ready;
      if (rd) begin
        exp_beat = q.pop_front();
        chk({tag, "_beat"}, 32'({m_last, m_data}), 32'(exp_beat));
        recv++;
      end
      if (wr) begin
        q.push_back({s_last, s_data});
        sent++;
        pkt_left--;
        pend = 1'b0;
      end else begin
        pend = s_valid;
      end
      prev_mv   = m_valid;
      prev_rd   = rd;
      prev_beat = {m_last, m_data};
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    chk({tag, "_beats_received"}, 32'(recv), 32'(NBEAT));
  endtask

  int sidx, ridx;

  initial begin
    sel     = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    rst     = 1'b0;
    #2;
    // ---------------- reset state ----------------
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_fill", 32'(fill), 32'd0);
    chk("rst_pkt", 32'(pkt_cnt), 32'd0);

    // ---------------- 1: mid-stream async reset, mode 0 ----------------
    do_reset(1'b0);
    s_valid = 1'b1; s_data = 8'h01; tick();
    s_data = 8'h02; tick();
    s_data = 8'h03;
    chk("t1_fill_before", 32'(fill), 32'd2);
    #2; rst = 1'b0; #1;
    chk("t1_async_m_valid", 32'(m_valid), 32'd0);
    chk("t1_async_s_ready", 32'(s_ready), 32'd1);
    chk("t1_async_fill", 32'(fill), 32'd0);
    chk("t1_async_pkt", 32'(pkt_cnt), 32'd0);
    s_valid = 1'b0; #1; rst = 1'b1;
    tick();
    chk("t1_post_fill", 32'(fill), 32'd0);
    s_valid = 1'b1; s_data = 8'h55; tick();
    s_valid = 1'b0;
    chk("t1_post_m_valid", 32'(m_valid), 32'd1);
    chk("t1_post_m_data", 32'(m_data), 32'h55);
    chk("t1_post_fill1", 32'(fill), 32'd1);

    // ---------------- 2: fill to full, drain, mode 0 ----------------
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 8'(8'h11 * (i + 1)); s_last = 1'b0;
      tick();
    end
    s_valid = 1'b0;
    chk("t2_full_s_ready", 32'(s_ready), 32'd0);
    chk("t2_full_fill", 32'(fill), 32'd4);
    chk("t2_full_m_valid", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_rd_data", 32'(m_data), 32'(8'h11 * (i + 1)));
      tick();
      if (i == 0) chk("t2_s_ready_after_rd", 32'(s_ready), 32'd1);
    end
    m_ready = 1'b0;
    chk("t2_end_fill", 32'(fill), 32'd0);
    chk("t2_end_m_valid", 32'(m_valid), 32'd0);

    // ---------------- 3: store-and-forward hold-off, mode 1 ----------------
    do_reset(1'b1);
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 8'hA0; s_last = 1'b0; tick();
    chk("t3_hold_a0", 32'(m_valid), 32'd0);
    s_data = 8'hA1; tick();
    chk("t3_hold_a1", 32'(m_valid), 32'd0);
    chk("t3_fill2", 32'(fill), 32'd2);
    s_data = 8'hA2; s_last = 1'b1; tick();
    s_valid = 1'b0; s_last = 1'b0;
    chk("t3_rel_valid", 32'(m_valid), 32'd1);
    chk("t3_pkt1", 32'(pkt_cnt), 32'd1);
    chk("t3_beat0", 32'({m_last, m_data}), 32'h0A0);
    tick();
    chk("t3_valid1", 32'(m_valid), 32'd1);
    chk("t3_beat1", 32'({m_last, m_data}), 32'h0A1);
    tick();
    chk("t3_valid2", 32'(m_valid), 32'd1);
    chk("t3_beat2", 32'({m_last, m_data}), 32'h1A2);
    chk("t3_pkt_still1", 32'(pkt_cnt), 32'd1);
    tick();
    m_ready = 1'b0;
    chk("t3_done_valid", 32'(m_valid), 32'd0);
    chk("t3_pkt0", 32'(pkt_cnt), 32'd0);

    // ---------------- 4: simultaneous read/write with wrap, mode 0 ----------
    do_reset(1'b0);
    s_valid = 1'b1; s_data = 8'h30; tick();
    s_data = 8'h31; tick();
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_data = 8'(8'h32 + i);
      chk("t4_rd_data", 32'(m_data), 32'(8'h30 + i));
      tick();
      chk("t4_fill", 32'(fill), 32'd2);
    end
    s_valid = 1'b0;
    chk("t4_drain0", 32'(m_data), 32'h3A);
    tick();
    chk("t4_drain1", 32'(m_data), 32'h3B);
    tick();
    m_ready = 1'b0;
    chk("t4_empty", 32'(fill), 32'd0);

    // ---------------- 5: oversize packet escape, mode 1 ----------------
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 8'(8'hB0 + i); s_last = 1'b0;
      tick();
    end
    s_valid = 1'b0;
    chk("t5_full_s_ready", 32'(s_ready), 32'd0);
    chk("t5_full_valid", 32'(m_valid), 32'd1);
    chk("t5_full_pkt", 32'(pkt_cnt), 32'd0);
    m_ready = 1'b1;
    sidx = 4;
    ridx = 0;
    for (int cyc = 0; cyc < 40 && ridx < 6; cyc++) begin
      if (sidx < 6) begin
        s_valid = 1'b1; s_data = 8'(8'hB0 + sidx); s_last = (sidx == 5);
      end else begin
        s_valid = 1'b0; s_last = 1'b0;
      end
      #1;
      if (m_valid && m_ready) begin
        chk("t5_beat", 32'({m_last, m_data}), 32'({(ridx == 5), 8'(8'hB0 + ridx)}));
        ridx++;
      end
      if (s_valid && s_ready) sidx++;
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    chk("t5_count", 32'(ridx), 32'd6);
    chk("t5_fill", 32'(fill), 32'd0);
    chk("t5_pkt", 32'(pkt_cnt), 32'd0);

    // ---------------- 6: randomised traffic, both modes ----------------
    run_random(1'b0, "r0");
    run_random(1'b1, "r1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
